ldpc_term_ctrl: RTL and testbench

- Iteration and early-termination controller for the (204,102) binary LDPC decoder.
- Sits directly downstream of the GF(2) parity-check (H·cwᵀ) stage. Each decoder iteration it consumes that stage's single "syndrome non-zero" flag together with the hard-decision codeword.
- Decides whether to request another iteration or stop. On stop, it latches the information bits and presents them through a valid/ready output handshake with success status and iteration count.

---
 rtl/ldpc_term_ctrl_pkg.sv | 24 ++
 rtl/ldpc_term_ctrl_sat_cnt.sv | 32 +++
 rtl/ldpc_term_ctrl.sv | 141 ++++++++++++++
 tb/tb_ldpc_term_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_term_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ldpc_term_ctrl_pkg
// Shared constants and FSM state encoding for the (204,102) LDPC iteration /
// early-termination controller.
//   LDPC_N        : codeword length
//   LDPC_K        : information length (information bits are cw[K-1:0])
//   LDPC_MAX_ITER : maximum decoder iterations per frame
//   LDPC_ITER_W   : width of the iteration counter
//   term_state_t  : controller states IDLE / ITER / OUT
// ----------------------------------------------------------------------------
package ldpc_term_ctrl_pkg;

   localparam int LDPC_N        = 204;
   localparam int LDPC_K        = 102;
   localparam int LDPC_MAX_ITER = 20;
   localparam int LDPC_ITER_W   = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      OUT  = 2'd2
   } term_state_t;

endpackage

// File: rtl/ldpc_term_ctrl_sat_cnt.sv
// ----------------------------------------------------------------------------
// ldpc_sat_cnt
// 16-bit saturating event counter with synchronous clear, used for the frame
// and failure statistics. Only built when LDPC_TERM_STATS_EN is defined.
//   clk   : clock
//   rst   : asynchronous reset, active high
//   clr   : synchronous clear, wins over inc
//   inc   : count one event
//   count : current count, sticks at 16'hFFFF
// ----------------------------------------------------------------------------
`ifdef LDPC_TERM_STATS_EN
module ldpc_sat_cnt (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        inc,
   output logic [15:0] count
);

   // Clear has priority; once at all-ones the counter holds instead of wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= 16'd0;
      end else if (clr) begin
         count <= 16'd0;
      end else if (inc && (count != 16'hFFFF)) begin
         count <= count + 16'd1;
      end
   end

endmodule
`endif

// File: rtl/ldpc_term_ctrl.sv
// ----------------------------------------------------------------------------
// ldpc_term_ctrl
// Iteration and early-termination controller for the (204,102) LDPC decoder.
// Requests decoder iterations with iter_go, watches the parity-check stage's
// syndrome flag after each iteration, and on a zero syndrome or after
// MAX_ITER iterations latches the information bits and offers them on a
// valid/ready output with success status and iteration count.
//   clk, rst      : clock, asynchronous active-high reset
//   start         : new frame loaded into the decoder (pulse)
//   cw_in         : hard-decision codeword after the current iteration
//   cw_valid      : iteration finished, cw_in/syndrome_fail valid (pulse)
//   syndrome_fail : 1 = syndrome non-zero
//   iter_go       : run one decoder iteration (pulse)
//   busy          : frame in progress until the output transfer completes
//   dec_valid/dec_ready : output handshake
//   dec_data      : latched cw_in[K-1:0]
//   dec_success   : frame terminated on a zero syndrome
//   dec_iters     : iterations actually run
// Optional (macro LDPC_TERM_STATS_EN):
//   clr_stats     : synchronous clear of both statistics counters
//   frm_cnt       : transferred frames, saturating
//   fail_cnt      : transferred frames with dec_success=0, saturating
// ----------------------------------------------------------------------------
module ldpc_term_ctrl
   import ldpc_term_ctrl_pkg::*;
#(
   parameter int N        = LDPC_N,
   parameter int K        = LDPC_K,
   parameter int MAX_ITER = LDPC_MAX_ITER,
   parameter int ITER_W   = LDPC_ITER_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [N-1:0]      cw_in,
   input  logic              cw_valid,
   input  logic              syndrome_fail,
   output logic              iter_go,
   output logic              busy,
   output logic              dec_valid,
   input  logic              dec_ready,
   output logic [K-1:0]      dec_data,
   output logic              dec_success,
   output logic [ITER_W-1:0] dec_iters
`ifdef LDPC_TERM_STATS_EN
   ,
   input  logic              clr_stats,
   output logic [15:0]       frm_cnt,
   output logic [15:0]       fail_cnt
`endif
);

   localparam logic [ITER_W-1:0] MAX_CNT = ITER_W'(MAX_ITER);

   term_state_t       state;
   logic [ITER_W-1:0] cnt;
   logic [ITER_W-1:0] cnt_next;
   logic              unused_cw_parity;

   assign cnt_next = cnt + 1'b1;

   // The parity part of the codeword is only needed by the syndrome stage.
   assign unused_cw_parity = ^cw_in[N-1:K];

   // Main controller. Every output is a register so iter_go appears one
   // cycle after the event that requests it and can never overlap dec_valid
   // (iter_go is only raised on paths that stay out of OUT). Termination is
   // forced when cnt_next reaches MAX_ITER, so the counter cannot wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         iter_go     <= 1'b0;
         busy        <= 1'b0;
         dec_valid   <= 1'b0;
         dec_data    <= '0;
         dec_success <= 1'b0;
         dec_iters   <= '0;
      end else begin
         iter_go <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  cnt     <= '0;
                  iter_go <= 1'b1;
                  busy    <= 1'b1;
                  state   <= ITER;
               end
            end
            ITER: begin
               if (cw_valid) begin
                  cnt <= cnt_next;
                  if (!syndrome_fail || (cnt_next == MAX_CNT)) begin
                     dec_data    <= cw_in[K-1:0];
                     dec_success <= ~syndrome_fail;
                     dec_iters   <= cnt_next;
                     dec_valid   <= 1'b1;
                     state       <= OUT;
                  end else begin
                     iter_go <= 1'b1;
                  end
               end
            end
            OUT: begin
               if (dec_ready) begin
                  dec_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef LDPC_TERM_STATS_EN
   logic xfer;

   // dec_valid is only high in OUT, so the handshake alone marks a transfer.
   assign xfer = dec_valid & dec_ready;

   ldpc_sat_cnt u_frm_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr_stats),
      .inc   (xfer),
      .count (frm_cnt)
   );

   ldpc_sat_cnt u_fail_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr_stats),
      .inc   (xfer & ~dec_success),
      .count (fail_cnt)
   );
`endif

endmodule

// File: tb/tb_ldpc_term_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ldpc_term_ctrl
// Self-checking bench for ldpc_term_ctrl. Expected frame results are pushed to
// a scoreboard queue when a frame is driven and popped when the DUT offers the
// frame on its output handshake. iter_go pulses are counted by a monitor.
// Statistics checks are included when LDPC_TERM_STATS_EN is defined.
// ----------------------------------------------------------------------------
module tb_ldpc_term_ctrl;
   import ldpc_term_ctrl_pkg::*;

   localparam int N        = LDPC_N;
   localparam int K        = LDPC_K;
   localparam int MAX_ITER = LDPC_MAX_ITER;
   localparam int ITER_W   = LDPC_ITER_W;

   typedef struct {
      logic [K-1:0]      data;
      logic              ok;
      logic [ITER_W-1:0] iters;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [N-1:0]      cw_in = '0;
   logic              cw_valid = 1'b0;
   logic              syndrome_fail = 1'b0;
   logic              iter_go;
   logic              busy;
   logic              dec_valid;
   logic              dec_ready = 1'b0;
   logic [K-1:0]      dec_data;
   logic              dec_success;
   logic [ITER_W-1:0] dec_iters;
`ifdef LDPC_TERM_STATS_EN
   logic              clr_stats = 1'b0;
   logic [15:0]       frm_cnt;
   logic [15:0]       fail_cnt;
   int                exp_frm = 0;
   int                exp_fail = 0;
`endif

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fails = 0;
   int   go_cnt = 0;
   int   frame_go_base = 0;

   ldpc_term_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .cw_in         (cw_in),
      .cw_valid      (cw_valid),
      .syndrome_fail (syndrome_fail),
      .iter_go       (iter_go),
      .busy          (busy),
      .dec_valid     (dec_valid),
      .dec_ready     (dec_ready),
      .dec_data      (dec_data),
      .dec_success   (dec_success),
      .dec_iters     (dec_iters)
`ifdef LDPC_TERM_STATS_EN
      ,
      .clr_stats     (clr_stats),
      .frm_cnt       (frm_cnt),
      .fail_cnt      (fail_cnt)
`endif
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   // Count iter_go pulses; at a rising edge the pre-edge value is seen, so
   // every one-cycle pulse is counted exactly once.
   always @(posedge clk) begin
      if (iter_go) go_cnt <= go_cnt + 1;
   end

   // Overall time limit so the run can never hang.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // One comparison: counts it and reports a failure with tag and values.
   task automatic checkValue(input string tag, input logic [127:0] obs,
                             input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Drive one frame: iterations 1..n_fail report a non-zero syndrome, the
   // next reports zero. The expected result is queued before driving.
   task automatic applyStimulus(input int n_fail, input logic [K-1:0] info);
      exp_t          e;
      int            exp_iters;
      bit            seen;
      logic [127:0]  r;
      logic [127:0]  r2;
      e.ok      = (n_fail < MAX_ITER);
      exp_iters = e.ok ? n_fail + 1 : MAX_ITER;
      e.data    = info;
      e.iters   = ITER_W'(exp_iters);
      exp_q.push_back(e);
      frame_go_base = go_cnt;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkValue("go_latency", {127'd0, iter_go}, 128'd1);
      checkValue("busy_after_start", {127'd0, busy}, 128'd1);
      for (int it = 1; it <= exp_iters; it++) begin
         seen = 1'b0;
         for (int t = 0; t < 50 && !seen; t++) begin
            if (iter_go) seen = 1'b1;
            else @(negedge clk);
         end
         checkValue("go_wait", {127'd0, seen}, 128'd1);
         if (!seen) return;
         @(negedge clk);
         r  = rand128();
         r2 = rand128();
         cw_in         = {r[N-K-1:0], (it == exp_iters) ? info : r2[K-1:0]};
         syndrome_fail = (it <= n_fail);
         cw_valid      = 1'b1;
         @(negedge clk);
         cw_valid      = 1'b0;
         syndrome_fail = 1'b0;
      end
   endtask

   // Wait for the frame, compare against the scoreboard, optionally hold
   // dec_ready low for `hold` cycles while pulsing start, then transfer.
   task automatic checkOutput(input int hold, input bit clr);
      exp_t e;
      bit   seen;
      int   go_frame;
      seen = 1'b0;
      for (int t = 0; t < 10 && !seen; t++) begin
         if (dec_valid) seen = 1'b1;
         else @(negedge clk);
      end
      checkValue("out_wait", {127'd0, seen}, 128'd1);
      checkValue("sb_not_empty", {127'd0, exp_q.size() != 0}, 128'd1);
      if (!seen || exp_q.size() == 0) return;
      e = exp_q.pop_front();
      checkValue("dec_data", {26'd0, dec_data}, {26'd0, e.data});
      checkValue("dec_success", {127'd0, dec_success}, {127'd0, e.ok});
      checkValue("dec_iters", {123'd0, dec_iters}, {123'd0, e.iters});
      checkValue("go_with_valid", {127'd0, iter_go}, 128'd0);
      checkValue("busy_in_out", {127'd0, busy}, 128'd1);
      for (int c = 0; c < hold; c++) begin
         dec_ready = 1'b0;
         start     = (c == 3);
         @(negedge clk);
      end
      start = 1'b0;
      if (hold > 0) begin
         checkValue("hold_valid", {127'd0, dec_valid}, 128'd1);
         checkValue("hold_data", {26'd0, dec_data}, {26'd0, e.data});
         checkValue("hold_iters", {123'd0, dec_iters}, {123'd0, e.iters});
         checkValue("hold_success", {127'd0, dec_success}, {127'd0, e.ok});
      end
      dec_ready = 1'b1;
`ifdef LDPC_TERM_STATS_EN
      clr_stats = clr;
`endif
      @(negedge clk);
      dec_ready = 1'b0;
`ifdef LDPC_TERM_STATS_EN
      clr_stats = 1'b0;
      if (clr) begin
         exp_frm  = 0;
         exp_fail = 0;
      end else begin
         exp_frm++;
         if (!e.ok) exp_fail++;
      end
      checkValue("frm_cnt", {112'd0, frm_cnt}, 128'(exp_frm));
      checkValue("fail_cnt", {112'd0, fail_cnt}, 128'(exp_fail));
`else
      if (clr) $display("[TB] stats clear requested without stats build");
`endif
      checkValue("valid_after_xfer", {127'd0, dec_valid}, 128'd0);
      checkValue("busy_after_xfer", {127'd0, busy}, 128'd0);
      checkValue("data_kept", {26'd0, dec_data}, {26'd0, e.data});
      repeat (3) @(negedge clk);
      go_frame = go_cnt - frame_go_base;
      checkValue("go_count", 128'(go_frame), 128'(e.iters));
      checkValue("idle_busy", {127'd0, busy}, 128'd0);
   endtask

   initial begin
      logic [K-1:0] alt;
      logic [127:0] r;
      int           base;

      $display("[TB] start");
      alt = {51{2'b10}};

      // Reset state.
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkValue("rst_iter_go", {127'd0, iter_go}, 128'd0);
      checkValue("rst_busy", {127'd0, busy}, 128'd0);
      checkValue("rst_valid", {127'd0, dec_valid}, 128'd0);
      checkValue("rst_data", {26'd0, dec_data}, 128'd0);
      checkValue("rst_success", {127'd0, dec_success}, 128'd0);
      checkValue("rst_iters", {123'd0, dec_iters}, 128'd0);

      // cw_valid and dec_ready in IDLE are ignored.
      cw_in = {102'd0, alt};
      cw_valid = 1'b1;
      dec_ready = 1'b1;
      @(negedge clk);
      cw_valid = 1'b0;
      dec_ready = 1'b0;
      @(negedge clk);
      checkValue("idle_cw_valid", {127'd0, dec_valid}, 128'd0);
      checkValue("idle_busy0", {127'd0, busy}, 128'd0);
      checkValue("idle_go", 128'(go_cnt), 128'd0);

      // Immediate success with alternating information bits.
      applyStimulus(0, alt);
      checkOutput(0, 1'b0);

      // Late success on iteration 7.
      r = rand128();
      applyStimulus(6, r[K-1:0]);
      checkOutput(0, 1'b0);

      // Exhaustion: every iteration fails.
      r = rand128();
      applyStimulus(MAX_ITER, r[K-1:0]);
      checkOutput(0, 1'b0);

      // Backpressure with start pulsed while the frame waits.
      r = rand128();
      applyStimulus(2, r[K-1:0]);
      checkOutput(10, 1'b0);

      // Reset mid-frame after three failing iterations.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int it = 0; it < 3; it++) begin
         @(negedge clk);
         cw_in = {rand128(), rand128()};
         syndrome_fail = 1'b1;
         cw_valid = 1'b1;
         @(negedge clk);
         cw_valid = 1'b0;
         syndrome_fail = 1'b0;
      end
      checkValue("pre_rst_busy", {127'd0, busy}, 128'd1);
      #2;
      rst = 1'b1;
      #1;
      checkValue("arst_iter_go", {127'd0, iter_go}, 128'd0);
      checkValue("arst_busy", {127'd0, busy}, 128'd0);
      checkValue("arst_valid", {127'd0, dec_valid}, 128'd0);
      checkValue("arst_data", {26'd0, dec_data}, 128'd0);
      checkValue("arst_success", {127'd0, dec_success}, 128'd0);
      checkValue("arst_iters", {123'd0, dec_iters}, 128'd0);
`ifdef LDPC_TERM_STATS_EN
      checkValue("arst_frm", {112'd0, frm_cnt}, 128'd0);
      exp_frm  = 0;
      exp_fail = 0;
`endif
      @(negedge clk);
      rst = 1'b0;
      base = go_cnt;
      repeat (5) @(negedge clk);
      checkValue("no_go_after_rst", 128'(go_cnt - base), 128'd0);
      checkValue("idle_after_rst", {127'd0, busy}, 128'd0);

      // Fresh frame after reset counts from 1.
      r = rand128();
      applyStimulus(1, r[K-1:0]);
      checkOutput(0, 1'b0);

      // Two more frames, one exhausted: three frames since reset, one failed.
      r = rand128();
      applyStimulus(MAX_ITER, r[K-1:0]);
      checkOutput(0, 1'b0);
      r = rand128();
      applyStimulus(0, r[K-1:0]);
      checkOutput(0, 1'b0);

      // Clear of the statistics coincident with a transfer wins.
      r = rand128();
      applyStimulus(MAX_ITER, r[K-1:0]);
      checkOutput(0, 1'b1);

      checkValue("sb_drained", 128'(exp_q.size()), 128'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fails);
      $finish;
   end

endmodule
